// File: rtl/port_rx_pkg.sv
// Shared types and constants for the switch output-port receiver.
package port_rx_pkg;

    // Position within the packet currently being reassembled.
    typedef enum logic [2:0] {
        S_DA,
        S_SA,
        S_LEN,
        S_DATA,
        S_FCS
    } rx_state_e;

    localparam logic [1:0] ERR_OK  = 2'b00;
    localparam logic [1:0] ERR_FCS = 2'b01;
    localparam logic [1:0] ERR_DA  = 2'b10;
    localparam logic [1:0] ERR_LEN = 2'b11;

    // DA, SA and LEN precede the payload.
    localparam int unsigned HDR_BYTES = 3;

    // Only the most severe error is reported: DA, then length, then FCS.
    function automatic logic [1:0] err_select(input logic da_err,
                                              input logic len_err,
                                              input logic fcs_err);
        if (da_err) begin
            return ERR_DA;
        end else if (len_err) begin
            return ERR_LEN;
        end else if (fcs_err) begin
            return ERR_FCS;
        end
        return ERR_OK;
    endfunction

endpackage

// File: rtl/port_receiver_if.sv
// Port FIFO read side plus the forwarded byte stream of one receiver.
interface port_receiver_if;

    logic       ready_in;
    logic       read_out;
    logic [7:0] port_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_sop;
    logic       out_eop;

    // Receiver side.
    modport master (
        input  ready_in,
        input  port_data,
        input  out_ready,
        output read_out,
        output out_valid,
        output out_data,
        output out_sop,
        output out_eop
    );

    // Switch FIFO and downstream sink side.
    modport slave (
        output ready_in,
        output port_data,
        output out_ready,
        input  read_out,
        input  out_valid,
        input  out_data,
        input  out_sop,
        input  out_eop
    );

endinterface

// File: rtl/port_rx_sat_cnt.sv
// Event counter that sticks at all-ones instead of wrapping.
module port_rx_sat_cnt #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;

    // Count up on inc until saturated.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (inc && (count_q != '1)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/port_receiver.sv
// Drains one switch output FIFO, reassembles DA/SA/LEN/payload/FCS,
// checks the packet and forwards every byte on a valid/ready stream.
module port_receiver
    import port_rx_pkg::*;
#(
    parameter int unsigned MIN_LEN = 1,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    port_receiver_if.master  bus,
    input  logic [7:0]       exp_addr,
    output logic             pkt_done,
    output logic             pkt_err,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] pkt_count,
    output logic [CNT_W-1:0] err_count
);

    rx_state_e  state_q;
    logic [7:0] rem_q;
    logic [7:0] acc_q;
    logic       pending_q;
    logic       out_valid_q;
    logic [7:0] out_data_q;
    logic       out_sop_q;
    logic       out_eop_q;
    logic       done_q;
    logic       err_q;
    logic [1:0] code_q;
    logic       da_err_q;
    logic       len_err_q;

    logic       read_d;
    logic       len_short;
    logic       fcs_bad;
    logic [1:0] code_d;

    // Issue a read only when nothing is in flight and the output register
    // is free (or being emptied this edge), so returning data always fits.
    always_comb begin
        read_d    = bus.ready_in & ~pending_q & (~out_valid_q | bus.out_ready) & ~reset;
        len_short = (32'(bus.port_data) < MIN_LEN);
        fcs_bad   = (bus.port_data != acc_q);
        code_d    = err_select(da_err_q, len_err_q, fcs_bad);
    end

    assign bus.read_out = read_d;

    // Packet FSM: one capture per returned read, with registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_DA;
            rem_q       <= '0;
            acc_q       <= '0;
            pending_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            code_q      <= ERR_OK;
            da_err_q    <= 1'b0;
            len_err_q   <= 1'b0;
        end else begin
            pending_q <= read_d;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            if (pending_q) begin
                out_valid_q <= 1'b1;
                out_data_q  <= bus.port_data;
                out_sop_q   <= (state_q == S_DA);
                out_eop_q   <= (state_q == S_FCS);
                case (state_q)
                    S_DA: begin
                        acc_q     <= bus.port_data;
                        da_err_q  <= (bus.port_data != exp_addr);
                        len_err_q <= 1'b0;
                        state_q   <= S_SA;
                    end
                    S_SA: begin
                        acc_q   <= acc_q ^ bus.port_data;
                        state_q <= S_LEN;
                    end
                    S_LEN: begin
                        acc_q     <= acc_q ^ bus.port_data;
                        len_err_q <= len_short;
                        rem_q     <= bus.port_data;
                        state_q   <= (bus.port_data == 8'd0) ? S_FCS : S_DATA;
                    end
                    S_DATA: begin
                        acc_q <= acc_q ^ bus.port_data;
                        rem_q <= rem_q - 8'd1;
                        if (rem_q == 8'd1) begin
                            state_q <= S_FCS;
                        end
                    end
                    S_FCS: begin
                        done_q  <= 1'b1;
                        err_q   <= (code_d != ERR_OK);
                        code_q  <= code_d;
                        state_q <= S_DA;
                    end
                    default: state_q <= S_DA;
                endcase
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sop   = out_sop_q;
    assign bus.out_eop   = out_eop_q;
    assign pkt_done      = done_q;
    assign pkt_err       = err_q;
    assign err_code      = code_q;

    port_rx_sat_cnt #(
        .CNT_W(CNT_W)
    ) u_pkt_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (done_q),
        .count (pkt_count)
    );

    port_rx_sat_cnt #(
        .CNT_W(CNT_W)
    ) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (done_q & err_q),
        .count (err_count)
    );

endmodule
